// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity types, legal prescale
// values, the transmit-path mux select and a majority-vote helper.
package uart_pkg;

  localparam int unsigned ST_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [ST_W-1:0] ST_START  = 3'd1;
  localparam logic [ST_W-1:0] ST_DATA   = 3'd2;
  localparam logic [ST_W-1:0] ST_PARITY = 3'd3;
  localparam logic [ST_W-1:0] ST_STOP   = 3'd4;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int unsigned PRESCALE_8  = 8;
  localparam int unsigned PRESCALE_16 = 16;
  localparam int unsigned PRESCALE_32 = 32;

  // Output mux select shared with the transmit path.
  typedef enum logic [1:0] {
    MUX_START = 2'd0,
    MUX_STOP  = 2'd1,
    MUX_DATA  = 2'd2,
    MUX_PAR   = 2'd3
  } mux_sel_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit oversampling: edge counter, three mid-bit samples and majority vote.
// Strobes are combinational (_c) and only asserted while active.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic                  clk_rx,
  input  logic                  rst_rx,
  input  logic                  active,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  rx,
  output logic                  sample_done_c,
  output logic                  bit_val_c,
  output logic                  bit_end_c
);

  logic [PRESCALE_W-1:0] edge_cnt;
  logic [PRESCALE_W-1:0] half_c;
  logic [PRESCALE_W-1:0] last_c;
  logic                  smp_a;
  logic                  smp_b;

  assign half_c = prescale >> 1;
  assign last_c = prescale - PRESCALE_W'(1);

  // Wraps at the latched P-1 whatever P is, so odd prescales cannot stall it.
  always_ff @(posedge clk_rx or negedge rst_rx) begin
    if (!rst_rx) begin
      edge_cnt <= '0;
    end else if (!active || (edge_cnt == last_c)) begin
      edge_cnt <= '0;
    end else begin
      edge_cnt <= edge_cnt + PRESCALE_W'(1);
    end
  end

  // First two samples are held; the third is the live line at resolve time.
  always_ff @(posedge clk_rx or negedge rst_rx) begin
    if (!rst_rx) begin
      smp_a <= 1'b1;
      smp_b <= 1'b1;
    end else if (active) begin
      if (edge_cnt == (half_c - PRESCALE_W'(1))) begin
        smp_a <= rx;
      end
      if (edge_cnt == half_c) begin
        smp_b <= rx;
      end
    end
  end

  assign sample_done_c = active && (edge_cnt == (half_c + PRESCALE_W'(1)));
  assign bit_val_c     = maj3(smp_a, smp_b, rx);
  assign bit_end_c     = active && (edge_cnt == last_c);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start detect, LSB-first deserialize, optional parity and stop check.
// Optional UART_RX_SYNC_EN adds a 2-flop input synchronizer (2 cycles extra latency).
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic                  clk_rx,
  input  logic                  rst_rx,
  input  logic                  rx_in_rx,
  input  logic [PRESCALE_W-1:0] prescale_rx,
  input  logic                  par_en_rx,
  input  logic                  par_typ_rx,
  output logic [DATA_WIDTH-1:0] p_data_rx,
  output logic                  data_valid_rx,
  output logic                  par_err_rx,
  output logic                  stp_err_rx
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic                  rx_c;
  logic [ST_W-1:0]       state;
  logic [ST_W-1:0]       state_nxt;
  logic [PRESCALE_W-1:0] prescale_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  par_err_q;
  logic [DATA_WIDTH-1:0] shreg;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  active_c;
  logic                  latch_cfg_c;
  logic                  par_calc_c;
  logic                  dv_nxt;
  logic                  pe_nxt;
  logic                  se_nxt;
  logic                  sample_done_c;
  logic                  bit_val_c;
  logic                  bit_end_c;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk_rx or negedge rst_rx) begin
    if (!rst_rx) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx_in_rx};
    end
  end

  assign rx_c = sync_q[1];
`else
  assign rx_c = rx_in_rx;
`endif

  assign active_c   = (state != ST_IDLE);
  assign par_calc_c = (^shreg) ^ (par_typ_q == PAR_ODD);

  uart_rx_sampler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_sampler (
    .clk_rx        (clk_rx),
    .rst_rx        (rst_rx),
    .active        (active_c),
    .prescale      (prescale_q),
    .rx            (rx_c),
    .sample_done_c (sample_done_c),
    .bit_val_c     (bit_val_c),
    .bit_end_c     (bit_end_c)
  );

  always_ff @(posedge clk_rx or negedge rst_rx) begin
    if (!rst_rx) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and next-cycle frame result pulses.
  always_comb begin
    state_nxt   = state;
    latch_cfg_c = 1'b0;
    dv_nxt      = 1'b0;
    pe_nxt      = 1'b0;
    se_nxt      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!rx_c) begin
          state_nxt   = ST_START;
          latch_cfg_c = 1'b1;
        end
      end
      ST_START: begin
        if (sample_done_c && bit_val_c) begin
          state_nxt = ST_IDLE;
        end else if (bit_end_c) begin
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end_c && (bit_cnt == LAST_BIT)) begin
          state_nxt = par_en_q ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (bit_end_c) begin
          state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (sample_done_c) begin
          state_nxt = ST_IDLE;
          dv_nxt    = bit_val_c && !par_err_q;
          pe_nxt    = par_err_q;
          se_nxt    = !bit_val_c;
        end else if (bit_end_c) begin
          // Degenerate prescale never reaches the resolve point; drop the frame.
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Frame configuration, deserializer, bit counter and parity record.
  always_ff @(posedge clk_rx or negedge rst_rx) begin
    if (!rst_rx) begin
      prescale_q <= PRESCALE_W'(PRESCALE_8);
      par_en_q   <= 1'b0;
      par_typ_q  <= PAR_EVEN;
      par_err_q  <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
    end else begin
      if (latch_cfg_c) begin
        prescale_q <= prescale_rx;
        par_en_q   <= par_en_rx;
        par_typ_q  <= par_typ_rx;
        par_err_q  <= 1'b0;
        bit_cnt    <= '0;
      end
      if ((state == ST_DATA) && sample_done_c) begin
        shreg <= {bit_val_c, shreg[DATA_WIDTH-1:1]};
      end
      if ((state == ST_DATA) && bit_end_c) begin
        bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + CNT_W'(1);
      end
      if ((state == ST_PARITY) && sample_done_c) begin
        par_err_q <= (bit_val_c != par_calc_c);
      end
    end
  end

  // Registered outputs; p_data_rx only moves with a good frame.
  always_ff @(posedge clk_rx or negedge rst_rx) begin
    if (!rst_rx) begin
      p_data_rx     <= '0;
      data_valid_rx <= 1'b0;
      par_err_rx    <= 1'b0;
      stp_err_rx    <= 1'b0;
    end else begin
      data_valid_rx <= dv_nxt;
      par_err_rx    <= pe_nxt;
      stp_err_rx    <= se_nxt;
      if (dv_nxt) begin
        p_data_rx <= shreg;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level model predicts each result pulse
// from the stop-bit time and the sent bits; outputs are compared every cycle.
module tb_uart_rx;

`ifdef UART_RX_SYNC_EN
  localparam int unsigned SYNC_LAT = 2;
`else
  localparam int unsigned SYNC_LAT = 0;
`endif

  typedef struct {
    int unsigned t;
    logic        dv;
    logic        pe;
    logic        se;
    logic [7:0]  data;
  } ev_t;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [5:0] prescale;
  logic       par_en;
  logic       par_typ;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          obs_dv = 0;
  int          obs_pe = 0;
  int          obs_se = 0;
  ev_t         exp_q[$];
  logic [7:0]  dv_log[$];
  logic [7:0]  exp_pdata = 8'h00;
  logic [10:0] exp_vec;
  logic [10:0] act_vec;
  ev_t         cur_ev;

  uart_rx #(
    .DATA_WIDTH (8),
    .PRESCALE_W (6)
  ) dut (
    .clk_rx        (clk),
    .rst_rx        (rst_n),
    .rx_in_rx      (rx),
    .prescale_rx   (prescale),
    .par_en_rx     (par_en),
    .par_typ_rx    (par_typ),
    .p_data_rx     (p_data),
    .data_valid_rx (data_valid),
    .par_err_rx    (par_err),
    .stp_err_rx    (stp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Per-cycle comparison of {valid, par_err, stp_err, data} against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_pdata = 8'h00;
      exp_vec   = '0;
    end else begin
      exp_vec = {3'b000, exp_pdata};
      if (exp_q.size() != 0 && exp_q[0].t == cyc) begin
        cur_ev = exp_q.pop_front();
        if (cur_ev.dv) exp_pdata = cur_ev.data;
        exp_vec = {cur_ev.dv, cur_ev.pe, cur_ev.se, exp_pdata};
      end
    end
    act_vec = {data_valid, par_err, stp_err, p_data};
    chk("outputs", 32'(act_vec), 32'(exp_vec));
    if (rst_n) begin
      if (data_valid === 1'b1) begin
        obs_dv++;
        dv_log.push_back(p_data);
      end
      if (par_err === 1'b1) obs_pe++;
      if (stp_err === 1'b1) obs_se++;
    end
  end

  task automatic drive_bit(input logic b, input int unsigned p);
    rx = b;
    repeat (p) @(negedge clk);
  endtask

  function automatic int unsigned pick_presc();
    case ($urandom_range(0, 2))
      0:       return 8;
      1:       return 16;
      default: return 32;
    endcase
  endfunction

  // Sends one frame starting at a negedge and predicts its result.
  task automatic send_frame(input logic [7:0] data, input int unsigned p, input logic pen,
                            input logic ptyp, input logic flip, input logic stop,
                            input logic scramble, input int unsigned gap);
    logic pbit;
    ev_t  ev;
    int   ones;
    logic par_ok;
    pbit     = (^data) ^ ptyp ^ flip;
    prescale = 6'(p);
    par_en   = pen;
    par_typ  = ptyp;
    drive_bit(1'b0, p);
    for (int i = 0; i < 8; i++) begin
      if (scramble && i == 2) begin
        prescale = 6'(pick_presc());
        par_en   = 1'($urandom);
        par_typ  = 1'($urandom);
      end
      drive_bit(data[i], p);
    end
    if (pen) drive_bit(pbit, p);
    prescale = 6'(p);
    par_en   = pen;
    par_typ  = ptyp;
    ones   = $countones({data, pbit});
    par_ok = !pen || ((ones % 2) == (ptyp ? 1 : 0));
    ev.t    = cyc + p / 2 + 3 + SYNC_LAT;
    ev.dv   = stop && par_ok;
    ev.pe   = !par_ok;
    ev.se   = !stop;
    ev.data = data;
    exp_q.push_back(ev);
    drive_bit(stop, p);
    rx = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, p0, s0, n0;
    int unsigned p;
    logic stop;
    rst_n = 1'b1; rx = 1'b1; prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0;
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    repeat (5) @(negedge clk);

    // P=8 even parity, good frame
    d0 = obs_dv; p0 = obs_pe; s0 = obs_se;
    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 24);
    chk("t1_valid_count", 32'(obs_dv - d0), 32'd1);
    chk("t1_parerr_count", 32'(obs_pe - p0), 32'd0);
    chk("t1_stperr_count", 32'(obs_se - s0), 32'd0);
    chk("t1_data", 32'(p_data), 32'h0000_00A5);

    // P=16 odd parity, parity bit flipped
    d0 = obs_dv; p0 = obs_pe;
    send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 40);
    chk("t2_parerr_count", 32'(obs_pe - p0), 32'd1);
    chk("t2_valid_count", 32'(obs_dv - d0), 32'd0);
    chk("t2_data_held", 32'(p_data), 32'h0000_00A5);

    // P=32 no parity, stop bit low
    d0 = obs_dv; s0 = obs_se;
    send_frame(8'h81, 32, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 72);
    chk("t3_stperr_count", 32'(obs_se - s0), 32'd1);
    chk("t3_valid_count", 32'(obs_dv - d0), 32'd0);

    // P=8 two-cycle glitch, then a good frame
    d0 = obs_dv; p0 = obs_pe; s0 = obs_se;
    prescale = 6'd8; par_en = 1'b0;
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (24) @(negedge clk);
    chk("t4_glitch_silent", 32'((obs_dv - d0) + (obs_pe - p0) + (obs_se - s0)), 32'd0);
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 24);
    chk("t4_valid_count", 32'(obs_dv - d0), 32'd1);
    chk("t4_data", 32'(p_data), 32'h0000_0055);

    // P=16 back-to-back frames, no idle gap
    n0 = dv_log.size();
    send_frame(8'h01, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    send_frame(8'hFE, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    send_frame(8'h7F, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 40);
    chk("t5_valid_count", 32'(dv_log.size() - n0), 32'd3);
    if (dv_log.size() >= n0 + 3) begin
      chk("t5_data0", 32'(dv_log[n0]), 32'h0000_0001);
      chk("t5_data1", 32'(dv_log[n0 + 1]), 32'h0000_00FE);
      chk("t5_data2", 32'(dv_log[n0 + 2]), 32'h0000_007F);
    end

    // Reset mid-DATA of 0xC3, then 0x5A
    prescale = 6'd16; par_en = 1'b0; par_typ = 1'b0;
    drive_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'hC3 >> i), 16);
    @(posedge clk); #2 rst_n = 1'b0; rx = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("t6_reset_data", 32'(p_data), 32'd0);
    repeat (20) @(negedge clk);
    d0 = obs_dv;
    send_frame(8'h5A, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 40);
    chk("t6_valid_count", 32'(obs_dv - d0), 32'd1);
    chk("t6_data", 32'(p_data), 32'h0000_005A);

    // Randomized frames with mid-frame config changes
    for (int k = 0; k < 40; k++) begin
      p    = pick_presc();
      stop = ($urandom_range(0, 4) != 0);
      send_frame(8'($urandom), p, 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) == 0), stop, 1'($urandom),
                 stop ? $urandom_range(0, p) : 2 * p + 8);
    end
    repeat (80) @(negedge clk);
    chk("pending_events", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receive block, the receive-side counterpart of the transmit path (serializer, parity generator, output mux).
- Oversamples the serial line, detects the start bit and majority-samples each bit.
- Deserializes data LSB-first and checks optional parity and the stop bit.
- Presents each received frame as a parallel word with a one-cycle valid pulse.

Parameters:
DATA_WIDTH, 8, data bits per frame
PRESCALE_W, 6, width of prescale input; legal prescale values 8, 16, 32

Ports:
clk_rx  input  1  system clock (oversampling clock)
rst_rx  input  1  asynchronous active-low reset
rx_in_rx  input  1  serial line, idle high
prescale_rx  input  PRESCALE_W  clocks per bit (8/16/32)
par_en_rx  input  1  1 = parity bit present
par_typ_rx  input  1  0 = even, 1 = odd
p_data_rx  output  DATA_WIDTH  received data word
data_valid_rx  output  1  one-cycle pulse, p_data_rx valid
par_err_rx  output  1  one-cycle pulse, parity mismatch
stp_err_rx  output  1  one-cycle pulse, stop bit sampled low

Behaviour:
- Reset values: clk_rx single clock; rst_rx asynchronous active-low. On reset, all outputs are 0, the FSM goes to IDLE and all counters clear.
- Counters:
  - edge_cnt counts 0..prescale-1 within a bit.
  - bit_cnt counts data bits 0..DATA_WIDTH-1.
- Config latch: prescale_rx, par_en_rx and par_typ_rx are latched on the IDLE->START transition. Changes mid-frame are ignored.
- Sampling: samples are taken at edge_cnt = P/2-1, P/2 and P/2+1 (P = latched prescale). The bit value is the majority of the 3 samples, resolved at edge_cnt = P/2+1.
- FSM states:
  - IDLE: rx_in_rx = 0 -> START with edge_cnt = 0.
  - START: if the majority value is 1 (glitch), return to IDLE with no outputs. At edge_cnt = P-1, go to DATA.
  - DATA: shift the majority value into the shift register LSB-first. At edge_cnt = P-1 on the last bit, go to PARITY if par_en, else STOP.
  - PARITY: compare the sampled bit with the computed parity (XOR of data, inverted for odd). Record the mismatch. At edge_cnt = P-1, go to STOP.
  - STOP: resolve the stop bit at edge_cnt = P/2+1, then return to IDLE on the next cycle. This mid-stop return allows back-to-back frames with no idle gap.
- Frame result, registered on the cycle after the stop resolution, all flags for exactly one cycle:
  - Stop = 1 and no parity error: data_valid_rx = 1, p_data_rx loaded.
  - Stop = 1 with parity error: par_err_rx = 1, data_valid_rx = 0.
  - Stop = 0: stp_err_rx = 1, data_valid_rx = 0. par_err_rx is also pulsed if the parity also failed.
- p_data_rx holds its last value between frames. It updates only with data_valid_rx.
- Latency: data_valid_rx asserts P/2+2 clocks after the start of the stop bit at rx_in_rx, plus sync latency if enabled.
- rx_in_rx held low (break): the frame ends with stp_err_rx. The FSM then re-enters START immediately from IDLE and repeats stp_err_rx each frame time while the line stays low.
- Reset mid-frame: the frame is aborted, no pulses are produced, and the block waits for the next falling edge.
- Unsupported prescale values: behaviour is undefined but the FSM must not lock up. edge_cnt wraps at the latched P-1.

Optional Feature:
UART_RX_SYNC_EN
- Defined: rx_in_rx passes through a 2-flop synchronizer, reset to 1, before all logic. This adds 2 cycles of latency to every timing above.
- Undefined: rx_in_rx is used directly. The line is assumed synchronous to clk_rx.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding (IDLE/START/DATA/PARITY/STOP).
  - Parity type constants (PAR_EVEN = 0, PAR_ODD = 1).
  - Legal prescale constants (8/16/32).
  - The mux-select encoding already used by the transmit path.
- One natural sub-module: uart_rx_sampler. It contains edge_cnt, the 3-sample majority vote and a sample-done strobe. The FSM, deserializer and checkers stay in uart_rx.

Test Plan:
- Prescale 8, par_en = 1 even, frame 0xA5 with correct parity 0 -> data_valid_rx pulses once, p_data_rx = 0xA5, par_err_rx = 0, stp_err_rx = 0.
- Prescale 16, par_en = 1 odd, frame 0x3C with the parity bit flipped -> par_err_rx pulses once, data_valid_rx stays 0, p_data_rx keeps its previous value.
- Prescale 32, par_en = 0, frame 0x81 with stop bit driven 0 -> stp_err_rx pulses once, no data_valid_rx.
- Prescale 8, 2-cycle low glitch on the idle line -> returns to IDLE, no output pulses. A following valid frame 0x55 is received correctly.
- Prescale 16, par_en = 0, back-to-back frames 0x01, 0xFE, 0x7F with no idle gap -> three data_valid_rx pulses in order with correct data.
- Reset asserted mid-DATA of frame 0xC3, released, then frame 0x5A sent -> no pulse for the aborted frame, then data_valid_rx with p_data_rx = 0x5A.
